// File: rtl/sa_os_array.sv
// Output-stationary systolic array: ROWS x COLS signed MAC cells fed by skewed
// A (left edge) and B (top edge) operand streams, drained one row per handshake.
module sa_os_array #(
  parameter  int ROWS   = 4,
  parameter  int COLS   = 4,
  parameter  int DATA_W = 16,
  parameter  int ACC_W  = 32,
  parameter  int K_MAX  = 255,
  localparam int KW     = $clog2(K_MAX + 1),
  localparam int IW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_mode,
  input  logic                    i_start,
  input  logic [KW-1:0]           i_k_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*DATA_W-1:0]  a_in,
  input  logic [COLS*DATA_W-1:0]  b_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   out_row,
  output logic [IW-1:0]           out_row_idx,
  output logic                    busy,
  output logic                    done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int             FW         = $clog2(ROWS + COLS);
  localparam logic [FW-1:0]  FLUSH_LAST = FW'(ROWS + COLS - 2);
  localparam int             PW         = 2 * DATA_W;

  // Full-precision signed product, sign-extended, wrapping add (no saturation).
  function automatic logic signed [ACC_W-1:0] mac(
    input logic signed [ACC_W-1:0]  acc,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] ext;
    prod = PW'(a) * PW'(b);
    ext  = prod;
    return acc + ext;
  endfunction

  logic [1:0]    state;
  logic [KW-1:0] k_len_q;
  logic [KW-1:0] beat_cnt;
  logic [FW-1:0] flush_cnt;
  logic [IW-1:0] idx;
  logic          done_q;

  logic accept;
  logic acc_clr;

  logic [ROWS*COLS*DATA_W-1:0] a_pe;
  logic [ROWS*COLS*DATA_W-1:0] b_pe;
  logic [ROWS*COLS*ACC_W-1:0]  acc_flat;

  assign in_ready    = (state == S_LOAD);
  assign out_valid   = (state == S_DRAIN);
  assign busy        = (state != S_IDLE);
  assign done        = done_q;
  assign out_row_idx = idx;
  assign accept      = in_valid && in_ready;
  assign acc_clr     = (state == S_IDLE) && i_start && !i_mode;

  // Job control: IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      k_len_q   <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      idx       <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            k_len_q  <= i_k_len;
            beat_cnt <= '0;
            idx      <= '0;
            state    <= (i_k_len == '0) ? S_DRAIN : S_LOAD;
          end
        end
        S_LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt == k_len_q - KW'(1)) begin
              state     <= S_FLUSH;
              flush_cnt <= '0;
            end
          end
        end
        S_FLUSH: begin
          // Wait until the last beat has reached the far corner cell.
          if (flush_cnt == FLUSH_LAST) state <= S_DRAIN;
          else                         flush_cnt <= flush_cnt + FW'(1);
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (idx == IW'(ROWS - 1)) begin
              state  <= S_IDLE;
              idx    <= '0;
              done_q <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A skew: row r delays r cycles, then shifts right across the COLS cells
  for (genvar r = 0; r < ROWS; r++) begin : g_arow
    logic signed [DATA_W-1:0] a_skew [r+COLS];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < r + COLS; i++) a_skew[i] <= '0;
      end else begin
        a_skew[0] <= accept ? $signed(a_in[r*DATA_W +: DATA_W]) : '0;
        for (int i = 1; i < r + COLS; i++) a_skew[i] <= a_skew[i-1];
      end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_tap
      assign a_pe[(r*COLS+c)*DATA_W +: DATA_W] = a_skew[r+c];
    end
  end

  // B skew: column c delays c cycles, then shifts down across the ROWS cells
  for (genvar c = 0; c < COLS; c++) begin : g_bcol
    logic signed [DATA_W-1:0] b_skew [c+ROWS];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < c + ROWS; i++) b_skew[i] <= '0;
      end else begin
        b_skew[0] <= accept ? $signed(b_in[c*DATA_W +: DATA_W]) : '0;
        for (int i = 1; i < c + ROWS; i++) b_skew[i] <= b_skew[i-1];
      end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_tap
      assign b_pe[(r*COLS+c)*DATA_W +: DATA_W] = b_skew[c+r];
    end
  end

  // MAC cells: idle cycles see zero operands, so accumulating every cycle is harmless
  for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      logic signed [ACC_W-1:0] acc_q;

      always_ff @(posedge clk) begin
        if (rst || acc_clr) acc_q <= '0;
        else acc_q <= mac(acc_q,
                          $signed(a_pe[(r*COLS+c)*DATA_W +: DATA_W]),
                          $signed(b_pe[(r*COLS+c)*DATA_W +: DATA_W]));
      end

      assign acc_flat[(r*COLS+c)*ACC_W +: ACC_W] = acc_q;
    end
  end

  // Drain mux: accumulators are frozen in DRAIN, so the row is stable under backpressure
  always_comb begin
    out_row = '0;
    if (state == S_DRAIN) out_row = acc_flat[int'(idx)*COLS*ACC_W +: COLS*ACC_W];
  end

endmodule

// File: tb/tb_sa_os_array.sv
// Scoreboard bench for sa_os_array: a matrix model pushes expected rows per job,
// drained rows are popped and compared, plus latency/handshake/reset checks.
module tb_sa_os_array;
  localparam int R    = 4;
  localparam int C    = 4;
  localparam int DW   = 16;
  localparam int AW   = 32;
  localparam int KW   = 8;
  localparam int KMAX = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_mode = 1'b0;
  logic            i_start = 1'b0;
  logic [KW-1:0]   i_k_len = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [R*DW-1:0] a_in = '0;
  logic [C*DW-1:0] b_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [C*AW-1:0] out_row;
  logic [1:0]      out_row_idx;
  logic            busy;
  logic            done;

  sa_os_array #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(AW), .K_MAX(255)) dut (
    .clk(clk), .rst(rst), .i_mode(i_mode), .i_start(i_start), .i_k_len(i_k_len),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .busy(busy), .done(done)
  );

  typedef struct {
    logic [1:0]      idx;
    logic [C*AW-1:0] row;
  } exp_t;

  exp_t                  exp_q[$];
  logic signed [DW-1:0]  a_b [KMAX][R];
  logic signed [DW-1:0]  b_b [KMAX][C];
  logic signed [AW-1:0]  acc_m [R][C];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [C*AW-1:0] got, input logic [C*AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [R*DW-1:0] pack_a(input int j);
    logic [R*DW-1:0] v;
    for (int r = 0; r < R; r++) v[r*DW +: DW] = a_b[j][r];
    return v;
  endfunction

  function automatic logic [C*DW-1:0] pack_b(input int j);
    logic [C*DW-1:0] v;
    for (int c = 0; c < C; c++) v[c*DW +: DW] = b_b[j][c];
    return v;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) acc_m[r][c] = '0;
  endtask

  task automatic run_job(input logic mode, input int k, input int gap_at, input int gap_len,
                         input int stall_row, input int stall_len, input bit abort);
    int              t_last;
    int              stall_left;
    int              guard;
    bit              seen;
    bit              held;
    logic [C*AW-1:0] held_row;
    logic [1:0]      held_idx;
    exp_t            e;
    logic signed [AW-1:0] p;

    t_last = 0;
    @(posedge clk); #1;
    i_start = 1'b1; i_mode = mode; i_k_len = KW'(k);
    @(posedge clk); #1;
    i_start = 1'b0;
    if (!mode) clear_model();

    for (int j = 0; j < k; j++) begin
      if (j == gap_at) begin
        in_valid = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
      a_in = pack_a(j); b_in = pack_b(j); in_valid = 1'b1;
      @(negedge clk);
      check("in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      t_last = cyc;
      in_valid = 1'b0; a_in = '0; b_in = '0;
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++) begin
          p = AW'(a_b[j][r]) * AW'(b_b[j][c]);
          acc_m[r][c] = acc_m[r][c] + p;
        end
    end

    if (abort) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("pre_rst_busy", busy, 1'b1);
      check("pre_rst_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_busy", busy, 1'b0);
      check("abort_out_valid", out_valid, 1'b0);
      clear_model();
      seen = 1'b0;
      repeat (15) begin
        @(negedge clk);
        if (out_valid || done) seen = 1'b1;
      end
      check("abort_quiet", seen, 1'b0);
      return;
    end

    for (int r = 0; r < R; r++) begin
      e.idx = 2'(r);
      for (int c = 0; c < C; c++) e.row[c*AW +: AW] = acc_m[r][c];
      exp_q.push_back(e);
    end

    if (k > 0) begin
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (out_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check("first_vld_edge", seen ? cyc + 1 : 0, t_last + R + C);
    end else begin
      @(negedge clk);
    end

    held = 1'b0;
    held_row = '0;
    held_idx = '0;
    stall_left = stall_len;
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      guard++;
      if (out_valid) begin
        if (stall_left > 0 && int'(out_row_idx) == stall_row) begin
          if (held) begin
            check("hold_row", out_row, held_row);
            check("hold_idx", out_row_idx, held_idx);
          end else begin
            held = 1'b1; held_row = out_row; held_idx = out_row_idx;
          end
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          e = exp_q.pop_front();
          check("row", out_row, e.row);
          check("row_idx", out_row_idx, e.idx);
        end
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    check("done_pulse", done, 1'b1);
    check("idle_busy", busy, 1'b0);
    check("idle_out_valid", out_valid, 1'b0);
    @(negedge clk);
    check("done_clear", done, 1'b0);
  endtask

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out_row", out_row, '0);
    check("rst_out_row_idx", out_row_idx, 2'd0);

    // Single beat, column vector times ones
    for (int r = 0; r < R; r++) a_b[0][r] = DW'(r + 1);
    for (int c = 0; c < C; c++) b_b[0][c] = 16'sd1;
    run_job(1'b0, 1, -1, 0, -1, 0, 1'b0);

    // Identity, then accumulate the identity again
    for (int j = 0; j < 4; j++) begin
      for (int r = 0; r < R; r++) a_b[j][r] = (r == j) ? 16'sd1 : 16'sd0;
      for (int c = 0; c < C; c++) b_b[j][c] = (c == j) ? 16'sd1 : 16'sd0;
    end
    run_job(1'b0, 4, -1, 0, -1, 0, 1'b0);
    run_job(1'b1, 4, -1, 0, -1, 0, 1'b0);

    // Random operands: gapless, with a 3-cycle bubble, then with output backpressure
    for (int j = 0; j < 5; j++) begin
      for (int r = 0; r < R; r++) a_b[j][r] = DW'(int'($urandom_range(0, 400)) - 200);
      for (int c = 0; c < C; c++) b_b[j][c] = DW'(int'($urandom_range(0, 400)) - 200);
    end
    run_job(1'b0, 5, -1, 0, -1, 0, 1'b0);
    run_job(1'b0, 5, 2, 3, -1, 0, 1'b0);
    run_job(1'b0, 5, -1, 0, 1, 5, 1'b0);

    // Accumulator wrap, then a negative product
    for (int j = 0; j < 2; j++) begin
      for (int r = 0; r < R; r++) a_b[j][r] = -16'sd32768;
      for (int c = 0; c < C; c++) b_b[j][c] = -16'sd32768;
    end
    run_job(1'b0, 2, -1, 0, -1, 0, 1'b0);
    for (int r = 0; r < R; r++) a_b[0][r] = -16'sd1;
    for (int c = 0; c < C; c++) b_b[0][c] = 16'sd3;
    run_job(1'b0, 1, -1, 0, -1, 0, 1'b0);

    // Reset during FLUSH, then a mode-1 job must start from zero
    for (int j = 0; j < 2; j++) begin
      for (int r = 0; r < R; r++) a_b[j][r] = DW'(7 + r);
      for (int c = 0; c < C; c++) b_b[j][c] = DW'(9 - c);
    end
    run_job(1'b0, 2, -1, 0, -1, 0, 1'b1);
    for (int r = 0; r < R; r++) a_b[0][r] = DW'(r + 1);
    for (int c = 0; c < C; c++) b_b[0][c] = DW'(c + 5);
    run_job(1'b1, 1, -1, 0, -1, 0, 1'b0);

    // Zero-length mode-1 job drains the retained values directly
    run_job(1'b1, 0, -1, 0, -1, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
